sign_shaper: RTL and testbench

SIGN_SHAPER -- requirements
Module: sign_shaper

---
 rtl/sign_shaper.sv | 160 ++++++++++++++++
 tb/tb_sign_shaper.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sign_shaper.sv
// Hysteretic, glitch-filtered ADC-to-sign conditioner.
// Also measures the period between accepted rising edges.
module sign_shaper #(
  parameter int DATA_W = 8,
  parameter int FILT_N = 4,
  parameter int PER_W  = 32
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] th_high,
  input  logic [DATA_W-1:0] th_low,
  output logic              sign_out,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic [PER_W-1:0]  period,
  output logic              period_valid
);

  typedef enum logic [1:0] {
    LOW,
    RISE_CHK,
    HIGH,
    FALL_CHK
  } state_t;

  localparam logic [3:0]       FILT    = 4'(FILT_N);
  localparam logic [PER_W-1:0] PER_MAX = '1;
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic             rise_c;
  logic             fall_c;
  logic             rise_evt;
  logic             fall_evt;
  logic [PER_W-1:0] per_cnt;
  logic             armed;

  // With collapsed thresholds, fall simply means "below th_high".
  assign rise_c = adc_valid && (adc_data >= th_high);
  assign fall_c = adc_valid &&
                  ((th_low < th_high) ? (adc_data <= th_low)
                                      : (adc_data < th_high));

  // Filter FSM: next state, next count and edge events.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_evt  = 1'b0;
    fall_evt  = 1'b0;
    unique case (state)
      LOW: begin
        if (rise_c) begin
          if (FILT == 4'd1) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
            rise_evt  = 1'b1;
          end else begin
            state_nxt = RISE_CHK;
            cnt_nxt   = 4'd1;
          end
        end
      end
      RISE_CHK: begin
        if (adc_valid) begin
          if (rise_c) begin
            if (cnt + 4'd1 == FILT) begin
              state_nxt = HIGH;
              cnt_nxt   = '0;
              rise_evt  = 1'b1;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end else begin
            state_nxt = LOW;
            cnt_nxt   = '0;
          end
        end
      end
      HIGH: begin
        if (fall_c) begin
          if (FILT == 4'd1) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
            fall_evt  = 1'b1;
          end else begin
            state_nxt = FALL_CHK;
            cnt_nxt   = 4'd1;
          end
        end
      end
      FALL_CHK: begin
        if (adc_valid) begin
          if (fall_c) begin
            if (cnt + 4'd1 == FILT) begin
              state_nxt = LOW;
              cnt_nxt   = '0;
              fall_evt  = 1'b1;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end else begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register plus registered sign and edge strobes.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state      <= LOW;
      cnt        <= '0;
      sign_out   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sign_out   <= (state_nxt == HIGH) ||
                    (state_nxt == FALL_CHK);
      rise_pulse <= rise_evt;
      fall_pulse <= fall_evt;
    end
  end

  // Period meter: counter restarts at 1 on each rise, so the
  // value seen at the next rise is the edge-to-edge distance.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      per_cnt      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      armed        <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (rise_evt) begin
        per_cnt <= PER_ONE;
        armed   <= 1'b1;
        if (armed) begin
          period       <= per_cnt;
          period_valid <= 1'b1;
        end
      end else if (per_cnt != PER_MAX) begin
        per_cnt <= per_cnt + PER_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sign_shaper.sv
// Bench for sign_shaper: vector table plus directed
// sequences, checked through an expectation queue.
module tb_sign_shaper;

  localparam int DW = 8;
  localparam int PW = 8;

  logic          clk_50M = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] th_high = 8'd160;
  logic [DW-1:0] th_low = 8'd96;
  logic          sign_out;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [PW-1:0] period;
  logic          period_valid;

  sign_shaper #(
    .DATA_W(DW),
    .FILT_N(4),
    .PER_W (PW)
  ) dut (
    .clk_50M     (clk_50M),
    .rst         (rst),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .th_high     (th_high),
    .th_low      (th_low),
    .sign_out    (sign_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .period      (period),
    .period_valid(period_valid)
  );

  always #5 clk_50M = ~clk_50M;

  typedef struct {
    logic          s;
    logic          r;
    logic          f;
    logic          pv;
    logic [PW-1:0] per;
    string         tag;
  } exp_t;

  typedef struct {
    logic          rs;
    logic          v;
    logic [DW-1:0] d;
    logic          s;
    logic          r;
    logic          f;
  } vec_t;

  exp_t          sbq[$];
  vec_t          tbl[$];
  int            errors = 0;
  int            checks = 0;
  logic [PW-1:0] exp_per = '0;
  logic [DW-1:0] cur_thh = 8'd160;
  logic [DW-1:0] cur_thl = 8'd96;
  string         phase = "init";

  task automatic chk(input string n, input string t,
                     input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s/%s: got %0d expected %0d at %0t",
               t, n, a, e, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v,
                       input logic [DW-1:0] d,
                       input logic s, input logic rp,
                       input logic f, input logic pv);
    exp_t e;
    @(negedge clk_50M);
    rst       = r;
    adc_valid = v;
    adc_data  = d;
    th_high   = cur_thh;
    th_low    = cur_thl;
    if (r) exp_per = '0;
    e.s   = s;
    e.r   = rp;
    e.f   = f;
    e.pv  = pv;
    e.per = exp_per;
    e.tag = phase;
    sbq.push_back(e);
  endtask

  function automatic void add(input logic r, input logic v,
                              input int d, input logic s,
                              input logic rp, input logic f);
    vec_t t;
    t.rs = r;
    t.v  = v;
    t.d  = DW'(d);
    t.s  = s;
    t.r  = rp;
    t.f  = f;
    tbl.push_back(t);
  endfunction

  // Compare one queued expectation per clock, 1 ns after the edge.
  always begin
    exp_t e;
    @(posedge clk_50M);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sign_out", e.tag, int'(sign_out), int'(e.s));
      chk("rise_pulse", e.tag, int'(rise_pulse), int'(e.r));
      chk("fall_pulse", e.tag, int'(fall_pulse), int'(e.f));
      chk("period_valid", e.tag, int'(period_valid), int'(e.pv));
      chk("period", e.tag, int'(period), int'(e.per));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // basic rise, boundary fall at th_low, glitch filter
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, 100, 0, 0, 0);
    repeat (3) add(0, 1, 170, 0, 0, 0);
    add(0, 1, 170, 1, 1, 0);
    add(0, 1, 170, 1, 0, 0);
    repeat (3) add(0, 1, 96, 1, 0, 0);
    add(0, 1, 96, 0, 0, 1);
    add(0, 1, 90, 0, 0, 0);
    repeat (3) add(0, 1, 170, 0, 0, 0);
    add(0, 1, 120, 0, 0, 0);
    repeat (3) add(0, 1, 170, 0, 0, 0);
    // reset mid-filter, then rise exactly at th_high
    add(1, 1, 170, 0, 0, 0);
    repeat (3) add(0, 1, 160, 0, 0, 0);
    add(0, 1, 160, 1, 1, 0);
    // gapped valid: invalid cycles neither count nor clear
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, 170, 0, 0, 0);
    add(0, 0, 170, 0, 0, 0);
    add(0, 1, 170, 0, 0, 0);
    add(0, 0, 170, 0, 0, 0);
    add(0, 1, 170, 0, 0, 0);
    add(0, 0, 170, 0, 0, 0);
    add(0, 1, 170, 1, 1, 0);
    add(0, 0, 170, 1, 0, 0);

    phase = "table";
    foreach (tbl[i])
      drive(tbl[i].rs, tbl[i].v, tbl[i].d,
            tbl[i].s, tbl[i].r, tbl[i].f, 1'b0);

    phase = "hyst";
    repeat (50) drive(0, 1, 8'd120, 1, 0, 0, 0);
    repeat (3) drive(0, 1, 8'd90, 1, 0, 0, 0);
    drive(0, 1, 8'd90, 0, 0, 1, 0);

    phase = "fallback";
    cur_thl = 8'd200;
    cur_thh = 8'd160;
    drive(1, 0, 8'd0, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 8'd170, 0, 0, 0, 0);
    drive(0, 1, 8'd170, 1, 1, 0, 0);
    repeat (2) drive(0, 1, 8'd150, 1, 0, 0, 0);
    cur_thh = 8'd155;
    drive(0, 1, 8'd150, 1, 0, 0, 0);
    drive(0, 1, 8'd150, 0, 0, 1, 0);
    drive(0, 1, 8'd150, 0, 0, 0, 0);

    phase = "square";
    cur_thl = 8'd96;
    cur_thh = 8'd160;
    drive(1, 0, 8'd0, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 100; k++) begin
        if (p == 1 && k == 3) exp_per = 8'd100;
        drive(0, 1, (k < 50) ? 8'd200 : 8'd50,
              (k >= 3 && k < 53), (k == 3), (k == 53),
              (p > 0 && k == 3));
      end
    end

    phase = "saturate";
    repeat (300) drive(0, 1, 8'd50, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 8'd200, 0, 0, 0, 0);
    exp_per = 8'd255;
    drive(0, 1, 8'd200, 1, 1, 0, 1);
    drive(0, 1, 8'd200, 1, 0, 0, 0);

    repeat (3) @(posedge clk_50M);
    #2;
    chk("drain", "end", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
